// File: rtl/sprite_engine.sv
// sprite_engine: single palettised sprite overlaid on a raster stream.
//   Parameters: sprite source size SPR_W x SPR_H, display scale shift SCALE_SH,
//     palette index width IDX_W, screen SCR_W x SCR_H, start position
//     START_X/START_Y, reset velocity VEL_X0/VEL_Y0, edge MODE
//     (0 respawn, 1 bounce, 2 wrap).
//   Ports:
//     i_clk, i_rst_n           clock, synchronous active-low reset
//     i_x, i_y                 raster coordinate, result 2 cycles later
//     i_frame_start, i_move_en frame pulse, enable position step
//     i_vel_load/i_vel_x/_y    velocity load (signed 8-bit)
//     i_pix_*                  sprite memory write port (addr = row*SPR_W+col)
//     i_pal_*                  palette write port, data {R,G,B}
//     o_red/o_green/o_blue     pixel colour, 0 when no hit
//     o_sprite_hit             opaque sprite pixel
//     o_pos_x/o_pos_y          sprite top-left corner
//     o_event                  one-cycle pulse on respawn/bounce/wrap
module sprite_engine #(
   parameter int SPR_W    = 32,
   parameter int SPR_H    = 32,
   parameter int SCALE_SH = 2,
   parameter int IDX_W    = 4,
   parameter int SCR_W    = 1280,
   parameter int SCR_H    = 720,
   parameter int START_X  = 276,
   parameter int START_Y  = 96,
   parameter logic signed [7:0] VEL_X0 = -8'sd1,
   parameter logic signed [7:0] VEL_Y0 = 8'sd1,
   parameter int MODE     = 0
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic [15:0]                         i_x,
   input  logic [15:0]                         i_y,
   input  logic                                i_frame_start,
   input  logic                                i_move_en,
   input  logic                                i_vel_load,
   input  logic signed [7:0]                   i_vel_x,
   input  logic signed [7:0]                   i_vel_y,
   input  logic                                i_pix_we,
   input  logic [$clog2(SPR_W*SPR_H)-1:0]      i_pix_addr,
   input  logic [IDX_W-1:0]                    i_pix_data,
   input  logic                                i_pal_we,
   input  logic [IDX_W-1:0]                    i_pal_addr,
   input  logic [23:0]                         i_pal_data,
   output logic [7:0]                          o_red,
   output logic [7:0]                          o_green,
   output logic [7:0]                          o_blue,
   output logic                                o_sprite_hit,
   output logic [15:0]                         o_pos_x,
   output logic [15:0]                         o_pos_y,
   output logic                                o_event
);

   localparam int CW = $clog2(SPR_W);
   localparam int RW = $clog2(SPR_H);
   localparam int AW = CW + RW;
   localparam logic [16:0]        DISP_W17 = 17'(SPR_W << SCALE_SH);
   localparam logic [16:0]        DISP_H17 = 17'(SPR_H << SCALE_SH);
   localparam logic signed [16:0] MAX_X17  = 17'(SCR_W - (SPR_W << SCALE_SH));
   localparam logic signed [16:0] MAX_Y17  = 17'(SCR_H - (SPR_H << SCALE_SH));
   localparam logic [15:0]        START_X16 = 16'(START_X);
   localparam logic [15:0]        START_Y16 = 16'(START_Y);

   typedef struct packed {
      logic [15:0]        pos;
      logic signed [7:0]  vel;
      logic               out;
   } axis_t;

   // One axis of the position step. The velocity magnitude is far below the
   // span, so a single add/subtract of the span is enough for wrap.
   function automatic axis_t step_axis(input logic [15:0] pos,
                                       input logic signed [7:0] vel,
                                       input logic signed [16:0] max_p);
      logic signed [16:0] n;
      axis_t r;
      n     = $signed({1'b0, pos}) + $signed({{9{vel[7]}}, vel});
      r.pos = n[15:0];
      r.vel = vel;
      r.out = 1'b0;
      if (n[16]) begin
         r.out = 1'b1;
         if (MODE == 1) begin
            r.pos = '0;
            r.vel = -vel;
         end else if (MODE == 2) begin
            r.pos = n[15:0] + max_p[15:0] + 16'd1;
         end
      end else if (n > max_p) begin
         r.out = 1'b1;
         if (MODE == 1) begin
            r.pos = max_p[15:0];
            r.vel = -vel;
         end else if (MODE == 2) begin
            r.pos = n[15:0] - max_p[15:0] - 16'd1;
         end
      end
      return r;
   endfunction

   logic [IDX_W-1:0] spr_mem [SPR_W*SPR_H] = '{default: '0};
   logic [23:0]      pal_mem [2**IDX_W]    = '{default: '0};

   logic [15:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [15:0]       rpos_x_q, rpos_x_d, rpos_y_q, rpos_y_d;
   logic signed [7:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
   logic              event_q, event_d;
   logic              in_box_q, in_box_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              hit_q, hit_d;
   logic [23:0]       rgb_q, rgb_d;

   logic signed [7:0] vel_x_eff, vel_y_eff;
   axis_t             sx, sy;
   logic [15:0]       dx, dy;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [AW-1:0]     rd_addr;

   // A load coincident with a frame start steps with the new velocity.
   assign vel_x_eff = i_vel_load ? i_vel_x : vel_x_q;
   assign vel_y_eff = i_vel_load ? i_vel_y : vel_y_q;
   assign sx = step_axis(pos_x_q, vel_x_eff, MAX_X17);
   assign sy = step_axis(pos_y_q, vel_y_eff, MAX_Y17);

   always_comb begin
      pos_x_d  = pos_x_q;
      pos_y_d  = pos_y_q;
      vel_x_d  = vel_x_eff;
      vel_y_d  = vel_y_eff;
      event_d  = 1'b0;
      rpos_x_d = rpos_x_q;
      rpos_y_d = rpos_y_q;
      if (i_frame_start) begin
         if (i_move_en) begin
            event_d = sx.out | sy.out;
            vel_x_d = sx.vel;
            vel_y_d = sy.vel;
            if (MODE == 0 && event_d) begin
               pos_x_d = START_X16;
               pos_y_d = START_Y16;
            end else begin
               pos_x_d = sx.pos;
               pos_y_d = sy.pos;
            end
         end
         // The frame renders the position it has just stepped to.
         rpos_x_d = pos_x_d;
         rpos_y_d = pos_y_d;
      end
   end

   // Stage 1: box test and sprite memory read. Offsets wrap modulo 2^16 but
   // only matter inside the box where they are small and positive.
   assign dx      = i_x - rpos_x_q;
   assign dy      = i_y - rpos_y_q;
   assign col     = CW'(dx >> SCALE_SH);
   assign row     = RW'(dy >> SCALE_SH);
   assign rd_addr = {row, col};

   always_comb begin
      in_box_d = ({1'b0, i_x} >= {1'b0, rpos_x_q}) &&
                 ({1'b0, i_x} <  ({1'b0, rpos_x_q} + DISP_W17)) &&
                 ({1'b0, i_y} >= {1'b0, rpos_y_q}) &&
                 ({1'b0, i_y} <  ({1'b0, rpos_y_q} + DISP_H17));
      idx_d    = spr_mem[rd_addr];
      // Stage 2: palette lookup; index 0 is transparent.
      hit_d    = in_box_q && (idx_q != '0);
      rgb_d    = hit_d ? pal_mem[idx_q] : 24'h0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pos_x_q  <= START_X16;
         pos_y_q  <= START_Y16;
         rpos_x_q <= START_X16;
         rpos_y_q <= START_Y16;
         vel_x_q  <= VEL_X0;
         vel_y_q  <= VEL_Y0;
         event_q  <= 1'b0;
         in_box_q <= 1'b0;
         idx_q    <= '0;
         hit_q    <= 1'b0;
         rgb_q    <= '0;
      end else begin
         pos_x_q  <= pos_x_d;
         pos_y_q  <= pos_y_d;
         rpos_x_q <= rpos_x_d;
         rpos_y_q <= rpos_y_d;
         vel_x_q  <= vel_x_d;
         vel_y_q  <= vel_y_d;
         event_q  <= event_d;
         in_box_q <= in_box_d;
         idx_q    <= idx_d;
         hit_q    <= hit_d;
         rgb_q    <= rgb_d;
      end
   end

   // Reads above are taken combinationally before this edge's write, so a
   // same-cycle read of the written address returns the old contents.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && i_pix_we) spr_mem[i_pix_addr] <= i_pix_data;
      if (i_rst_n && i_pal_we) pal_mem[i_pal_addr] <= i_pal_data;
   end

   assign o_red        = rgb_q[23:16];
   assign o_green      = rgb_q[15:8];
   assign o_blue       = rgb_q[7:0];
   assign o_sprite_hit = hit_q;
   assign o_pos_x      = pos_x_q;
   assign o_pos_y      = pos_y_q;
   assign o_event      = event_q;

endmodule

// File: tb/tb_sprite_engine.sv
module tb_sprite_engine;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [15:0]       x, y;
   logic              frame_start, move_en, vel_load;
   logic signed [7:0] vel_x, vel_y;
   logic              pix_we;
   logic [9:0]        pix_addr;
   logic [3:0]        pix_data;
   logic              pal_we;
   logic [3:0]        pal_addr;
   logic [23:0]       pal_data;

   logic [7:0]  red [3], green [3], blue [3];
   logic        hit [3], ev [3];
   logic [15:0] pos_x [3], pos_y [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sprite_engine #(.MODE(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y),
      .i_frame_start(frame_start), .i_move_en(move_en),
      .i_vel_load(vel_load), .i_vel_x(vel_x), .i_vel_y(vel_y),
      .i_pix_we(pix_we), .i_pix_addr(pix_addr), .i_pix_data(pix_data),
      .i_pal_we(pal_we), .i_pal_addr(pal_addr), .i_pal_data(pal_data),
      .o_red(red[0]), .o_green(green[0]), .o_blue(blue[0]),
      .o_sprite_hit(hit[0]), .o_pos_x(pos_x[0]), .o_pos_y(pos_y[0]),
      .o_event(ev[0]));

   sprite_engine #(.MODE(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y),
      .i_frame_start(frame_start), .i_move_en(move_en),
      .i_vel_load(vel_load), .i_vel_x(vel_x), .i_vel_y(vel_y),
      .i_pix_we(pix_we), .i_pix_addr(pix_addr), .i_pix_data(pix_data),
      .i_pal_we(pal_we), .i_pal_addr(pal_addr), .i_pal_data(pal_data),
      .o_red(red[1]), .o_green(green[1]), .o_blue(blue[1]),
      .o_sprite_hit(hit[1]), .o_pos_x(pos_x[1]), .o_pos_y(pos_y[1]),
      .o_event(ev[1]));

   sprite_engine #(.MODE(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y),
      .i_frame_start(frame_start), .i_move_en(move_en),
      .i_vel_load(vel_load), .i_vel_x(vel_x), .i_vel_y(vel_y),
      .i_pix_we(pix_we), .i_pix_addr(pix_addr), .i_pix_data(pix_data),
      .i_pal_we(pal_we), .i_pal_addr(pal_addr), .i_pal_data(pal_data),
      .o_red(red[2]), .o_green(green[2]), .o_blue(blue[2]),
      .o_sprite_hit(hit[2]), .o_pos_x(pos_x[2]), .o_pos_y(pos_y[2]),
      .o_event(ev[2]));

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic        hit;
      logic [23:0] rgb;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pix_write(input logic [9:0] a, input logic [3:0] d);
      @(negedge clk);
      pix_we = 1'b1; pix_addr = a; pix_data = d;
      @(negedge clk);
      pix_we = 1'b0;
   endtask

   task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
      @(negedge clk);
      pal_we = 1'b1; pal_addr = a; pal_data = d;
      @(negedge clk);
      pal_we = 1'b0;
   endtask

   // Frame pulse; on return the stepped position and o_event are visible.
   task automatic step(input logic en, input logic ld, input int vx, input int vy);
      @(negedge clk);
      frame_start = 1'b1; move_en = en; vel_load = ld;
      vel_x = 8'(vx); vel_y = 8'(vy);
      @(negedge clk);
      frame_start = 1'b0; move_en = 1'b0; vel_load = 1'b0;
   endtask

   initial begin
      int ev_cnt;
      rst_n = 1'b1; x = '0; y = '0;
      frame_start = 1'b0; move_en = 1'b0; vel_load = 1'b0;
      vel_x = '0; vel_y = '0;
      pix_we = 1'b0; pix_addr = '0; pix_data = '0;
      pal_we = 1'b0; pal_addr = '0; pal_data = '0;

      vecs[0]  = '{16'd276, 16'd96,  1'b1, 24'h9AD2FF};
      vecs[1]  = '{16'd279, 16'd96,  1'b1, 24'h9AD2FF};
      vecs[2]  = '{16'd275, 16'd96,  1'b0, 24'h000000};
      vecs[3]  = '{16'd280, 16'd96,  1'b1, 24'h123456};
      vecs[4]  = '{16'd276, 16'd100, 1'b1, 24'hABCDEF};
      vecs[5]  = '{16'd403, 16'd223, 1'b1, 24'h9AD2FF};
      vecs[6]  = '{16'd404, 16'd223, 1'b0, 24'h000000};
      vecs[7]  = '{16'd403, 16'd224, 1'b0, 24'h000000};
      vecs[8]  = '{16'd284, 16'd96,  1'b0, 24'h000000};
      vecs[9]  = '{16'd276, 16'd95,  1'b0, 24'h000000};
      vecs[10] = '{16'd0,   16'd0,   1'b0, 24'h000000};

      do_reset();
      chk("reset_pos_x", 32'(pos_x[0]), 32'd276);
      chk("reset_pos_y", 32'(pos_y[0]), 32'd96);
      chk("reset_hit",   32'(hit[0]),   32'd0);
      chk("reset_rgb",   {8'h0, red[0], green[0], blue[0]}, 32'h0);
      chk("reset_event", 32'(ev[0]),    32'd0);

      pix_write(10'd0,    4'd1);
      pix_write(10'd1,    4'd2);
      pix_write(10'd32,   4'd3);
      pix_write(10'd1023, 4'd1);
      pal_write(4'd1, 24'h9AD2FF);
      pal_write(4'd2, 24'h123456);
      pal_write(4'd3, 24'hABCDEF);

      // Reset must beat a frame step, velocity load and memory write.
      @(negedge clk);
      rst_n = 1'b0; frame_start = 1'b1; move_en = 1'b1; vel_load = 1'b1;
      vel_x = 8'sd50; vel_y = 8'sd50;
      pix_we = 1'b1; pix_addr = 10'd0; pix_data = 4'd5;
      @(negedge clk);
      rst_n = 1'b1; frame_start = 1'b0; move_en = 1'b0; vel_load = 1'b0; pix_we = 1'b0;
      chk("rstprio_pos_x", 32'(pos_x[0]), 32'd276);
      chk("rstprio_event", 32'(ev[0]), 32'd0);
      step(1'b1, 1'b0, 0, 0);
      chk("rstprio_vel_x", 32'(pos_x[0]), 32'd275);
      chk("rstprio_vel_y", 32'(pos_y[0]), 32'd97);
      do_reset();

      // Render stream, one coordinate per cycle, result two cycles later.
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            chk($sformatf("render_hit[%0d]", k - 2), 32'(hit[0]), 32'(vecs[k-2].hit));
            chk($sformatf("render_rgb[%0d]", k - 2), {8'h0, red[0], green[0], blue[0]},
                {8'h0, vecs[k-2].rgb});
         end
         if (k < 11) begin
            x = vecs[k].x; y = vecs[k].y;
         end
      end

      // Same-cycle write and read of pix[3]: old data first, new data next.
      @(negedge clk);
      x = 16'd288; y = 16'd96;
      pix_we = 1'b1; pix_addr = 10'd3; pix_data = 4'd2;
      @(negedge clk);
      pix_we = 1'b0;
      @(negedge clk);
      chk("rdw_old_hit", 32'(hit[0]), 32'd0);
      chk("rdw_old_rgb", {8'h0, red[0], green[0], blue[0]}, 32'h0);
      @(negedge clk);
      chk("rdw_new_hit", 32'(hit[0]), 32'd1);
      chk("rdw_new_rgb", {8'h0, red[0], green[0], blue[0]}, 32'h123456);
      x = '0; y = '0;

      // Respawn: 276 steps of (-1,+1) reach (0,372), the next one respawns.
      do_reset();
      ev_cnt = 0;
      for (int i = 0; i < 276; i++) begin
         step(1'b1, 1'b0, 0, 0);
         if (ev[0]) ev_cnt++;
      end
      chk("respawn_pre_x", 32'(pos_x[0]), 32'd0);
      chk("respawn_pre_y", 32'(pos_y[0]), 32'd372);
      chk("respawn_pre_events", 32'(ev_cnt), 32'd0);
      step(1'b1, 1'b0, 0, 0);
      chk("respawn_x", 32'(pos_x[0]), 32'd276);
      chk("respawn_y", 32'(pos_y[0]), 32'd96);
      chk("respawn_event", 32'(ev[0]), 32'd1);
      @(negedge clk);
      chk("respawn_event_width", 32'(ev[0]), 32'd0);
      step(1'b1, 1'b0, 0, 0);
      chk("respawn_vel_kept", {pos_x[0], pos_y[0]}, {16'd275, 16'd97});

      // Bounce on the left edge.
      do_reset();
      step(1'b1, 1'b1, -128, 0);
      step(1'b1, 1'b1, -128, 0);
      step(1'b1, 1'b1, -18, 0);
      chk("bounce_pre_x", 32'(pos_x[1]), 32'd2);
      step(1'b1, 1'b1, -5, 0);
      chk("bounce_x", 32'(pos_x[1]), 32'd0);
      chk("bounce_y", 32'(pos_y[1]), 32'd96);
      chk("bounce_event", 32'(ev[1]), 32'd1);
      step(1'b1, 1'b0, 0, 0);
      chk("bounce_vel_neg", 32'(pos_x[1]), 32'd5);
      chk("bounce_event_clr", 32'(ev[1]), 32'd0);

      // Wrap on the right edge: span is 1153.
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 127, 0);
      step(1'b1, 1'b1, 112, 0);
      chk("wrap_pre_x", 32'(pos_x[2]), 32'd1150);
      chk("wrap_pre_event", 32'(ev[2]), 32'd0);
      step(1'b1, 1'b1, 5, 0);
      chk("wrap_x", 32'(pos_x[2]), 32'd2);
      chk("wrap_event", 32'(ev[2]), 32'd1);

      // Velocity load coincident with a frame start, then hold.
      do_reset();
      step(1'b1, 1'b1, -128, 0);
      step(1'b1, 1'b1, -48, 0);
      chk("vload_pre_x", 32'(pos_x[0]), 32'd100);
      step(1'b1, 1'b1, 3, 0);
      chk("vload_x", 32'(pos_x[0]), 32'd103);
      chk("vload_event", 32'(ev[0]), 32'd0);
      step(1'b0, 1'b0, 0, 0);
      chk("hold_x", 32'(pos_x[0]), 32'd103);
      chk("hold_y", 32'(pos_y[0]), 32'd96);
      step(1'b1, 1'b0, 0, 0);
      chk("hold_vel_kept", 32'(pos_x[0]), 32'd106);

      // The frame renders its freshly stepped position.
      @(negedge clk);
      x = 16'd106; y = 16'd96;
      @(negedge clk);
      @(negedge clk);
      chk("render_moved_hit", 32'(hit[0]), 32'd1);
      chk("render_moved_rgb", {8'h0, red[0], green[0], blue[0]}, 32'h9AD2FF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_engine.md
SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 SHALL have parameter SPR_W, default 32, sprite source width in pixels (power of 2).
REQ-002 SHALL have parameter SPR_H, default 32, sprite source height in pixels (power of 2).
REQ-003 SHALL have parameter SCALE_SH, default 2, display scale as a shift; footprint DISP_W=SPR_W<<SCALE_SH, DISP_H=SPR_H<<SCALE_SH.
REQ-004 SHALL have parameter IDX_W, default 4, palette index width; palette depth 2**IDX_W.
REQ-005 SHALL have parameters SCR_W and SCR_H, defaults 1280 and 720, screen size in pixels.
REQ-006 SHALL have parameters START_X and START_Y, defaults 276 and 96, start/respawn position.
REQ-007 SHALL have parameters VEL_X0 and VEL_Y0, defaults -1 and +1, reset velocity (signed 8-bit).
REQ-008 SHALL have parameter MODE, default 0: edge behaviour, 0=respawn, 1=bounce, 2=wrap.
REQ-009 i_clk  in  1  sole clock; all state on rising edge.
REQ-010 i_rst_n  in  1  reset, synchronous, active-low.
REQ-011 i_x, i_y  in  16 each  current raster coordinate.
REQ-012 i_frame_start  in  1  one-cycle pulse, once per frame.
REQ-013 i_move_en  in  1  enables the position step at i_frame_start.
REQ-014 i_vel_load, i_vel_x, i_vel_y  in  1/8/8  velocity load strobe and signed velocity.
REQ-015 i_pix_we, i_pix_addr, i_pix_data  in  1/log2(SPR_W*SPR_H)/IDX_W  sprite memory write port; addr = row*SPR_W+col.
REQ-016 i_pal_we, i_pal_addr, i_pal_data  in  1/IDX_W/24  palette write port; data = {R,G,B}.
REQ-017 o_red, o_green, o_blue  out  8 each  pixel colour.
REQ-018 o_sprite_hit  out  1  opaque sprite pixel present.
REQ-019 o_pos_x, o_pos_y  out  16 each  current sprite top-left corner.
REQ-020 o_event  out  1  one-cycle pulse on respawn, bounce or wrap.

Function
REQ-021 Render SHALL be a 2-stage pipeline: outputs reflect i_x/i_y presented 2 cycles earlier, one result per cycle, no stalls.
REQ-022 In-box SHALL be pos_x<=i_x<pos_x+DISP_W and pos_y<=i_y<pos_y+DISP_H, compared unsigned at 17 bits (no overflow).
REQ-023 Source column SHALL be (i_x-pos_x)>>SCALE_SH, row (i_y-pos_y)>>SCALE_SH.
REQ-024 Palette index 0 SHALL be transparent: o_sprite_hit=in-box AND index!=0.
REQ-025 When o_sprite_hit=0, o_red/o_green/o_blue SHALL be 0 (never X).
REQ-026 Memory write and render read to the same address in the same cycle SHALL return old data; new data visible the next cycle.
REQ-027 Position SHALL be captured for render at the i_frame_start pulse; mid-frame position changes SHALL NOT affect the current frame.
REQ-028 On i_frame_start with i_move_en=1: next=pos+vel, signed 17-bit; legal range x 0..SCR_W-DISP_W, y 0..SCR_H-DISP_H.
REQ-029 MODE 0: either axis out of range SHALL set pos=(START_X,START_Y), velocity unchanged, o_event=1.
REQ-030 MODE 1: out-of-range axis SHALL clamp to the violated edge and negate that velocity component, o_event=1.
REQ-031 MODE 2: out-of-range axis SHALL wrap modulo span (range+1), o_event=1.
REQ-032 i_move_en=0 SHALL hold position and velocity across frame starts.
REQ-033 i_vel_load SHALL load velocity; coincident with i_frame_start, the step SHALL use the newly loaded value.
REQ-034 Position, velocity and o_event SHALL update 1 cycle after i_frame_start; o_event SHALL be 1 cycle wide.

Reset
REQ-035 i_rst_n=0 at a clock edge SHALL set pos=(START_X,START_Y), vel=(VEL_X0,VEL_Y0), clear pipeline, RGB=0, o_sprite_hit=0, o_event=0.
REQ-036 Reset SHALL NOT clear sprite memory or palette; both are 0 at configuration.
REQ-037 Reset mid-frame SHALL take priority over i_frame_start, i_vel_load and writes in the same cycle.

Verification
REQ-038 Reset: i_rst_n low 1 cycle -> o_pos=(276,96), RGB=0, hit=0, o_event=0.
REQ-039 Render: pix[0]=1, pal[1]=0x9AD2FF, i_x/i_y=(276,96) -> 2 cycles later RGB=9A/D2/FF, hit=1; (279,96) same; (275,96) -> hit=0, RGB=0.
REQ-040 Respawn (MODE 0): vel(-1,+1), 276 steps -> pos (0,372); next step -> (276,96), o_event 1 cycle.
REQ-041 Bounce (MODE 1): pos_x=2, vel_x=-5, step -> pos_x=0, vel_x=+5, o_event=1.
REQ-042 Wrap (MODE 2): pos_x=1150, vel_x=+5, step -> pos_x=2, o_event=1.
REQ-043 Simultaneous i_vel_load (+3,0) with i_frame_start at pos_x=100 -> pos_x=103; i_move_en=0 -> pos held.
